// File: rtl/vgpr_wr1_load_gather_pkg.sv
// Shared constants, state encoding and helpers for the wr1 load-gather block.
package vgpr_wr1_load_gather_pkg;

    localparam int LANES       = 64;
    localparam int DW          = 32;
    localparam int ADDR_W      = 10;
    localparam int WFID_W      = 6;
    localparam int MAX_LOAD_DW = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } gather_state_t;

    // A load carries between 1 and MAX_LOAD_DW dwords per lane.
    function automatic logic count_legal(input logic [2:0] cnt);
        return (cnt != 3'd0) && (cnt <= 3'(MAX_LOAD_DW));
    endfunction

    // Per-dword enable pattern (1<<cnt)-1 for a legal count.
    function automatic logic [3:0] dword_mask(input logic [2:0] cnt);
        logic [3:0] mask;
        case (cnt)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            3'd3:    mask = 4'b0111;
            3'd4:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/vgpr_ld_stage_buf.sv
// Four-slot per-lane staging buffer. Each slot holds one dword for every lane.
// The output is the look-ahead view (contents after the current edge) in the
// VGPR wr1 layout, so the commit register can capture the final beat directly.
module vgpr_ld_stage_buf #(
    parameter int LANES = vgpr_wr1_load_gather_pkg::LANES,
    parameter int DW    = vgpr_wr1_load_gather_pkg::DW
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    clear,
    input  logic                                                    we,
    input  logic [1:0]                                              slot,
    input  logic [LANES*DW-1:0]                                     wdata,
    output logic [vgpr_wr1_load_gather_pkg::MAX_LOAD_DW*LANES*DW-1:0] packed_next
);
    import vgpr_wr1_load_gather_pkg::*;

    genvar gi, gj;
    generate
        for (gi = 0; gi < MAX_LOAD_DW; gi++) begin : g_slot
            logic [LANES*DW-1:0] slot_reg;
            logic [LANES*DW-1:0] slot_next;

            // Clear wipes every slot; a write in the same cycle still lands.
            always_comb begin
                slot_next = clear ? '0 : slot_reg;
                if (we && (slot == 2'(gi))) begin
                    slot_next = wdata;
                end
            end

            // Slot storage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                end
            end

            // Lane gj of this slot goes to dword gi of lane gj's 128-bit word.
            for (gj = 0; gj < LANES; gj++) begin : g_lane
                assign packed_next[(gj*MAX_LOAD_DW+gi)*DW +: DW] = slot_next[gj*DW +: DW];
            end
        end
    endgenerate

endmodule

// File: rtl/vgpr_wr1_load_gather.sv
// Gathers LSU load-return beats (one dword per lane per beat) and commits a
// whole 1..4 dword load to the VGPR wr1 port in a single write cycle.
module vgpr_wr1_load_gather #(
    parameter int LANES  = vgpr_wr1_load_gather_pkg::LANES,
    parameter int DW     = vgpr_wr1_load_gather_pkg::DW,
    parameter int ADDR_W = vgpr_wr1_load_gather_pkg::ADDR_W,
    parameter int WFID_W = vgpr_wr1_load_gather_pkg::WFID_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic                    ld_first,
    input  logic [ADDR_W-1:0]       ld_vgpr_base,
    input  logic [2:0]              ld_dword_count,
    input  logic [LANES-1:0]        ld_exec,
    input  logic [WFID_W-1:0]       ld_wfid,
    input  logic [LANES*DW-1:0]     ld_data,
    output logic [LANES-1:0]        wr1_en,
    output logic [3:0]              wr1_en_xoutof4,
    output logic [ADDR_W-1:0]       wr1_addr,
    output logic [4*LANES*DW-1:0]   wr1_data,
    output logic                    wb_done,
    output logic [WFID_W-1:0]       wb_done_wfid,
    output logic                    busy,
    output logic                    protocol_err
);
    import vgpr_wr1_load_gather_pkg::*;

    // One past the last VGPR address; a load may end exactly here.
    localparam logic [ADDR_W:0] ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};

    gather_state_t state_reg, state_next;

    logic [1:0]          beat_cnt_reg;
    logic [2:0]          cnt_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [LANES-1:0]    exec_reg;
    logic [WFID_W-1:0]   wfid_reg;

    logic [LANES-1:0]    wr1_en_reg;
    logic [3:0]          wr1_xoutof4_reg;
    logic [ADDR_W-1:0]   wr1_addr_reg;
    logic [4*LANES*DW-1:0] wr1_data_reg;
    logic                wb_done_reg;
    logic [WFID_W-1:0]   wb_done_wfid_reg;
    logic                busy_reg;
    logic                protocol_err_reg;

    logic                accept;
    logic                latch_hdr;
    logic                beat_inc;
    logic                buf_clear;
    logic                buf_we;
    logic [1:0]          buf_slot;
    logic                commit_go;
    logic                err_beat;
    logic                range_ok;

    // Header as seen by the commit decision: live inputs for a single-beat
    // load, latched copies otherwise.
    logic [ADDR_W-1:0]   hdr_base;
    logic [2:0]          hdr_cnt;
    logic [LANES-1:0]    hdr_exec;
    logic [WFID_W-1:0]   hdr_wfid;

    logic [4*LANES*DW-1:0] stage_next;

    vgpr_ld_stage_buf #(
        .LANES (LANES),
        .DW    (DW)
    ) u_stage_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (buf_clear),
        .we          (buf_we),
        .slot        (buf_slot),
        .wdata       (ld_data),
        .packed_next (stage_next)
    );

    // Next-state, beat routing and error decode.
    always_comb begin
        state_next = state_reg;
        ld_ready   = (state_reg != ST_COMMIT);
        accept     = ld_valid && (state_reg != ST_COMMIT);
        latch_hdr  = 1'b0;
        beat_inc   = 1'b0;
        buf_clear  = 1'b0;
        buf_we     = 1'b0;
        buf_slot   = beat_cnt_reg;
        commit_go  = 1'b0;
        err_beat   = 1'b0;
        hdr_base   = base_reg;
        hdr_cnt    = cnt_reg;
        hdr_exec   = exec_reg;
        hdr_wfid   = wfid_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (ld_first && count_legal(ld_dword_count)) begin
                        latch_hdr = 1'b1;
                        buf_clear = 1'b1;
                        buf_we    = 1'b1;
                        buf_slot  = 2'd0;
                        hdr_base  = ld_vgpr_base;
                        hdr_cnt   = ld_dword_count;
                        hdr_exec  = ld_exec;
                        hdr_wfid  = ld_wfid;
                        if (ld_dword_count == 3'd1) begin
                            commit_go  = 1'b1;
                            state_next = ST_COMMIT;
                        end else begin
                            state_next = ST_COLLECT;
                        end
                    end else begin
                        err_beat = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    if (ld_first) begin
                        // Stray header mid-load: drop it, keep collecting.
                        err_beat = 1'b1;
                    end else begin
                        buf_we   = 1'b1;
                        beat_inc = 1'b1;
                        if (({1'b0, beat_cnt_reg} + 3'd1) == cnt_reg) begin
                            commit_go  = 1'b1;
                            state_next = ST_COMMIT;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Reject loads that would run past the top of the register file.
    assign range_ok = (({1'b0, hdr_base} + {{(ADDR_W-2){1'b0}}, hdr_cnt}) <= ADDR_SPAN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Header latches and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= 2'd0;
            cnt_reg      <= 3'd0;
            base_reg     <= '0;
            exec_reg     <= '0;
            wfid_reg     <= '0;
        end else begin
            if (latch_hdr) begin
                cnt_reg  <= ld_dword_count;
                base_reg <= ld_vgpr_base;
                exec_reg <= ld_exec;
                wfid_reg <= ld_wfid;
            end
            if (commit_go) begin
                beat_cnt_reg <= 2'd0;
            end else if (latch_hdr) begin
                beat_cnt_reg <= 2'd1;
            end else if (beat_inc) begin
                beat_cnt_reg <= beat_cnt_reg + 2'd1;
            end
        end
    end

    // Registered wr1 bundle, completion pulse, busy and sticky error.
    // Enables and wb_done live for exactly the COMMIT cycle; address and
    // data hold until the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr1_en_reg       <= '0;
            wr1_xoutof4_reg  <= 4'b0000;
            wr1_addr_reg     <= '0;
            wr1_data_reg     <= '0;
            wb_done_reg      <= 1'b0;
            wb_done_wfid_reg <= '0;
            busy_reg         <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            wr1_en_reg      <= '0;
            wr1_xoutof4_reg <= 4'b0000;
            wb_done_reg     <= 1'b0;
            busy_reg        <= (state_next != ST_IDLE);
            if (commit_go) begin
                wr1_en_reg       <= range_ok ? hdr_exec : '0;
                wr1_xoutof4_reg  <= range_ok ? dword_mask(hdr_cnt) : 4'b0000;
                wr1_addr_reg     <= hdr_base;
                wr1_data_reg     <= stage_next;
                wb_done_reg      <= 1'b1;
                wb_done_wfid_reg <= hdr_wfid;
            end
            if (err_beat || (commit_go && !range_ok)) begin
                protocol_err_reg <= 1'b1;
            end
        end
    end

    assign wr1_en         = wr1_en_reg;
    assign wr1_en_xoutof4 = wr1_xoutof4_reg;
    assign wr1_addr       = wr1_addr_reg;
    assign wr1_data       = wr1_data_reg;
    assign wb_done        = wb_done_reg;
    assign wb_done_wfid   = wb_done_wfid_reg;
    assign busy           = busy_reg;
    assign protocol_err   = protocol_err_reg;

endmodule
